// File: rtl/gen_slot_arbiter.sv
// gen_slot_arbiter: round-robin arbiter that shares one downstream resource
// among NREQ generate-loop slots. Each ownership is followed by a one-cycle
// RELEASE turnaround and a return to IDLE, where the next owner is chosen.
// Optional build macro: GEN_SLOT_ARB_TIMEOUT_EN adds a MAXHOLD limit on each
// grant and a timeout pulse when that limit alone ends a grant.
module gen_slot_arbiter #(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned IDW     = 2,
    parameter int unsigned MAXHOLD = 15,
    parameter int unsigned HOLDW   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            rel,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            busy,
    output logic            timeout
);

    localparam int unsigned SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Reject parameter sets that cannot represent an owner or a hold count
    if ((2 ** IDW) < NREQ) begin : g_bad_idw
        $error("gen_slot_arbiter: IDW too narrow for NREQ");
    end
    if ((2 ** HOLDW) <= MAXHOLD) begin : g_bad_holdw
        $error("gen_slot_arbiter: HOLDW too narrow for MAXHOLD");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0]    gnt_id_q, gnt_id_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic              busy_q, busy_d;

    logic              found_c;
    logic [IDW-1:0]    winner_c;
    logic              own_req_c;
    logic              hold_hit_c;

`ifdef GEN_SLOT_ARB_TIMEOUT_EN
    logic [HOLDW-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
`endif

    // Round-robin search starting just after the last owner
    always_comb begin
        found_c  = 1'b0;
        winner_c = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            int unsigned cand;
            cand = (32'(ptr_q) + 32'd1 + k) % NREQ;
            if (!found_c && req[SW'(cand)]) begin
                found_c  = 1'b1;
                winner_c = IDW'(cand);
            end
        end
    end

    // Current owner still requesting (gnt is one-hot, so a mask suffices)
    assign own_req_c = |(req & gnt_q);

`ifdef GEN_SLOT_ARB_TIMEOUT_EN
    assign hold_hit_c = (cnt_q == HOLDW'(MAXHOLD));
`else
    assign hold_hit_c = 1'b0;
`endif

    // Next-state and registered-output logic
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q;
`ifdef GEN_SLOT_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    state_d  = ST_GRANT;
                    gnt_d    = NREQ'(1) << winner_c;
                    gnt_id_d = winner_c;
                    ptr_d    = winner_c;
                    busy_d   = 1'b1;
`ifdef GEN_SLOT_ARB_TIMEOUT_EN
                    cnt_d    = HOLDW'(1);
`endif
                end
            end
            ST_GRANT: begin
                if (rel || !own_req_c || hold_hit_c) begin
                    state_d  = ST_RELEASE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    busy_d   = 1'b0;
`ifdef GEN_SLOT_ARB_TIMEOUT_EN
                    cnt_d     = '0;
                    timeout_d = hold_hit_c && !rel && own_req_c;
`endif
                end else begin
`ifdef GEN_SLOT_ARB_TIMEOUT_EN
                    if (cnt_q != {HOLDW{1'b1}}) begin
                        cnt_d = cnt_q + HOLDW'(1);
                    end
`endif
                end
            end
            ST_RELEASE: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
`ifdef GEN_SLOT_ARB_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end
            default: begin
                state_d  = ST_IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= IDW'(NREQ - 1);
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
        end
    end

`ifdef GEN_SLOT_ARB_TIMEOUT_EN
    // Hold counter and timeout pulse registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = busy_q;

endmodule
